// File: rtl/cv32e40s_pkg.sv
// Shared types and constants for the OBI limiting interface.
package cv32e40s_pkg;

    // A-channel handling: payload passed straight through, or held in the capture register
    typedef enum logic [0:0] {
        TRANSPARENT = 1'b0,
        REGISTERED  = 1'b1
    } obi_if_state_e;

    // Reset value of every bit of the A-channel capture register
    localparam logic OBI_A_RESET_BIT = 1'b0;

    // Per-transaction bookkeeping carried from grant to response
    typedef struct packed {
        logic integrity;
        logic gntpar_err;
    } obi_resp_entry_t;

endpackage

// File: rtl/cv32e40s_obi_resp_fifo.sv
// Small FIFO carrying per-transaction attributes from grant to response.
// A pop while empty is ignored and the head then reads as zero.
module cv32e40s_obi_resp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             empty, full, do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push_i && (!full || do_pop);
    assign rdata_o = empty ? '0 : mem_q[rptr_q];

    // Storage, pointers and fill level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cv32e40s_obi_limit_interface.sv
// OBI master interface limiting the number of outstanding transactions, holding the
// A-channel payload stable while a request waits for grant, and tracking parity errors.
module cv32e40s_obi_limit_interface
    import cv32e40s_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned INTEGRITY       = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic                                   trans_valid_i,
    output logic                                   trans_ready_o,
    input  logic [ADDR_WIDTH-1:0]                  trans_addr_i,
    input  logic                                   trans_we_i,
    input  logic [DATA_WIDTH/8-1:0]                trans_be_i,
    input  logic [DATA_WIDTH-1:0]                  trans_wdata_i,
    input  logic                                   trans_integrity_i,

    output logic                                   resp_valid_o,
    output logic [DATA_WIDTH-1:0]                  resp_rdata_o,
    output logic                                   resp_err_o,
    output logic                                   resp_integrity_o,
    output logic                                   resp_integrity_err_o,

    output logic                                   obi_req_o,
    output logic                                   obi_reqpar_o,
    input  logic                                   obi_gnt_i,
    input  logic                                   obi_gntpar_i,
    output logic [ADDR_WIDTH-1:0]                  obi_addr_o,
    output logic                                   obi_we_o,
    output logic [DATA_WIDTH/8-1:0]                obi_be_o,
    output logic [DATA_WIDTH-1:0]                  obi_wdata_o,

    input  logic                                   obi_rvalid_i,
    input  logic                                   obi_rvalidpar_i,
    input  logic [DATA_WIDTH-1:0]                  obi_rdata_i,
    input  logic                                   obi_err_i,

    output logic                                   integrity_err_o,
    output logic                                   protocol_err_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW    = ADDR_WIDTH + 1 + BE_W + DATA_WIDTH + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    obi_if_state_e    state_q;
    logic [PW-1:0]    cap_q;
    logic [PW-1:0]    trans_payload, obi_payload;
    logic             req_integrity;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             credit, gnt_evt, cnt_dec;

    // Credit uses the registered count, so a slot freed by rvalid is usable only next cycle
    assign credit        = (cnt_q < MAX_CNT);
    assign obi_req_o     = (state_q == REGISTERED) ? 1'b1 : (trans_valid_i && credit);
    assign obi_reqpar_o  = ~obi_req_o;
    assign trans_ready_o = (state_q == TRANSPARENT) && credit;
    assign gnt_evt       = obi_req_o && obi_gnt_i;
    assign cnt_dec       = obi_rvalid_i && (cnt_q != '0);

    assign trans_payload = {trans_addr_i, trans_we_i, trans_be_i, trans_wdata_i, trans_integrity_i};
    assign obi_payload   = (state_q == REGISTERED) ? cap_q : trans_payload;
    assign {obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, req_integrity} = obi_payload;

    assign resp_valid_o   = obi_rvalid_i;
    assign resp_rdata_o   = obi_rdata_i;
    assign resp_err_o     = obi_err_i;
    assign protocol_err_o = obi_rvalid_i && (cnt_q == '0);
    assign outstanding_o  = cnt_q;

    // A-channel FSM: capture the payload when a request is not granted immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TRANSPARENT;
            cap_q   <= {PW{OBI_A_RESET_BIT}};
        end else begin
            case (state_q)
                TRANSPARENT: begin
                    if (obi_req_o && !obi_gnt_i) begin
                        state_q <= REGISTERED;
                        cap_q   <= trans_payload;
                    end
                end
                REGISTERED: begin
                    if (obi_gnt_i) begin
                        state_q <= TRANSPARENT;
                    end
                end
                default: state_q <= TRANSPARENT;
            endcase
        end
    end

    // Next outstanding count; grant and response together cancel out
    always_comb begin
        cnt_d = cnt_q;
        case ({gnt_evt, cnt_dec})
            2'b10:   if (cnt_q != MAX_CNT) cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding transaction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    if (INTEGRITY != 0) begin : gen_integrity
        obi_resp_entry_t push_entry, head_entry;
        logic            gntpar_err, rvalidpar_err;

        assign gntpar_err    = (obi_gnt_i == obi_gntpar_i);
        assign rvalidpar_err = (obi_rvalid_i == obi_rvalidpar_i);
        assign push_entry    = '{integrity: req_integrity, gntpar_err: gntpar_err};

        cv32e40s_obi_resp_fifo #(
            .DEPTH (MAX_OUTSTANDING),
            .WIDTH ($bits(obi_resp_entry_t))
        ) u_resp_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .push_i  (gnt_evt),
            .wdata_i (push_entry),
            .pop_i   (obi_rvalid_i),
            .rdata_o (head_entry)
        );

        assign resp_integrity_o     = head_entry.integrity;
        assign resp_integrity_err_o = rvalidpar_err || head_entry.gntpar_err;
        assign integrity_err_o      = gntpar_err || rvalidpar_err;
    end else begin : gen_no_integrity
        assign resp_integrity_o     = 1'b0;
        assign resp_integrity_err_o = 1'b0;
        assign integrity_err_o      = 1'b0;
    end

endmodule

// File: doc/cv32e40s_obi_limit_interface.md
CV32E40S_OBI_LIMIT_INTERFACE -- requirements
Module: cv32e40s_obi_limit_interface

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, OBI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, rdata/wdata width; legal values 32 or 64; BE width = DATA_WIDTH/8.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, legal range 1..8; maximum number of granted transactions without a response.
REQ-004 SHALL have parameter INTEGRITY, default 1; 0 removes all parity logic and ties the integrity outputs to 0.
REQ-005 SHALL use a single clock and a synchronous, active-low reset, as follows.
  - clk  in  1  clock; all state updates on its rising edge.
  - rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL provide the transaction request ports.
  - trans_valid_i  in  1  request valid.
  - trans_ready_o  out  1  request accepted when both trans_valid_i and trans_ready_o are high.
  - trans_addr_i  in  ADDR_WIDTH  address.
  - trans_we_i  in  1  write enable.
  - trans_be_i  in  DATA_WIDTH/8  byte enables.
  - trans_wdata_i  in  DATA_WIDTH  write data.
  - trans_integrity_i  in  1  PMA integrity attribute of the request.
REQ-007 SHALL provide the transaction response ports.
  - resp_valid_o  out  1  response valid; the consumer is always ready.
  - resp_rdata_o  out  DATA_WIDTH  read data.
  - resp_err_o  out  1  bus error.
  - resp_integrity_o  out  1  integrity attribute of the responding transaction.
  - resp_integrity_err_o  out  1  parity error attributed to this response.
REQ-008 SHALL provide the OBI A-channel ports.
  - obi_req_o  out  1  OBI request.
  - obi_reqpar_o  out  1  inverse of obi_req_o.
  - obi_gnt_i  in  1  OBI grant.
  - obi_gntpar_i  in  1  inverse of obi_gnt_i.
  - obi_addr_o  out  ADDR_WIDTH  address.
  - obi_we_o  out  1  write enable.
  - obi_be_o  out  DATA_WIDTH/8  byte enables.
  - obi_wdata_o  out  DATA_WIDTH  write data.
REQ-009 SHALL provide the OBI R-channel ports.
  - obi_rvalid_i  in  1  response valid.
  - obi_rvalidpar_i  in  1  inverse of obi_rvalid_i.
  - obi_rdata_i  in  DATA_WIDTH  read data.
  - obi_err_i  in  1  bus error.
REQ-010 SHALL provide the status ports.
  - integrity_err_o  out  1  immediate parity error.
  - protocol_err_o  out  1  unexpected rvalid.
  - outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count.

Function
REQ-011 SHALL implement an FSM with two states, TRANSPARENT and REGISTERED.
  - TRANSPARENT -> REGISTERED when obi_req_o=1 and obi_gnt_i=0.
  - REGISTERED -> TRANSPARENT when obi_gnt_i=1.
REQ-012 SHALL, in TRANSPARENT, drive obi_req_o = trans_valid_i && (outstanding_o < MAX_OUTSTANDING) and pass the A-channel payload through combinationally from trans_*.
REQ-013 SHALL, on the TRANSPARENT->REGISTERED transition, capture addr, we, be, wdata and integrity into registers.
REQ-014 SHALL, in REGISTERED, drive obi_req_o=1 and the A-channel payload from the captured registers, holding the payload stable until grant.
REQ-015 SHALL drive trans_ready_o = (state==TRANSPARENT) && (outstanding_o < MAX_OUTSTANDING).
REQ-016 SHALL NOT make a credit freed by obi_rvalid_i usable by a request in the same cycle.
REQ-017 SHALL update the outstanding counter as follows.
  - +1 on obi_req_o && obi_gnt_i.
  - -1 on obi_rvalid_i while the count is >0.
  - Both events in the same cycle leave the count unchanged.
  - The counter never exceeds MAX_OUTSTANDING and never underflows.
REQ-018 SHALL assert protocol_err_o combinationally when obi_rvalid_i=1 while outstanding_o==0; the counter stays at 0.
REQ-019 SHALL drive resp_valid_o, resp_rdata_o and resp_err_o directly from obi_rvalid_i, obi_rdata_i and obi_err_i, with zero latency.
REQ-020 SHALL, when INTEGRITY=1, push {integrity, gntpar_err} into the response FIFO (depth MAX_OUTSTANDING) on each grant and pop it on each obi_rvalid_i.
  - The head entry drives resp_integrity_o.
  - A push and a pop in the same cycle are both performed.
  - A pop while empty returns 0 and does not move the pointers.
REQ-021 SHALL compute gntpar_err = (obi_gnt_i == obi_gntpar_i) and rvalidpar_err = (obi_rvalid_i == obi_rvalidpar_i), both evaluated every cycle.
REQ-022 SHALL drive resp_integrity_err_o = rvalidpar_err || head.gntpar_err.
REQ-023 SHALL drive integrity_err_o = gntpar_err || rvalidpar_err.
REQ-024 SHALL tie resp_integrity_o, resp_integrity_err_o and integrity_err_o to 0 when INTEGRITY=0.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, reset the following state.
  - state = TRANSPARENT.
  - counter = 0.
  - FIFO emptied.
  - Captured payload = all zeros.
REQ-026 SHALL drive the post-reset outputs as follows.
  - obi_req_o = 0 when trans_valid_i=0.
  - obi_reqpar_o = 1.
  - trans_ready_o = 1.
  - outstanding_o = 0.
REQ-027 SHALL discard all in-flight bookkeeping when reset is applied mid-transaction; no pending request is replayed after reset.

Structure
REQ-028 SHALL use obi_if_state_e and the reset value of the A-channel capture register from cv32e40s_pkg.
REQ-029 SHALL implement the response FIFO as sub-module cv32e40s_obi_resp_fifo, parametrised by DEPTH and entry width.

Verification
REQ-030 Bench SHALL cover each of the following scenarios.
  - Back-to-back: MAX_OUTSTANDING=2, gnt=1 always, rvalid delayed 3 cycles -> exactly 2 grants, then trans_ready_o=0 until the first rvalid.
  - Stall: gnt held 0 for 4 cycles while trans_addr_i changes each cycle -> obi_addr_o stays at the first address; trans_ready_o=0 for cycles 2-4.
  - Simultaneous: outstanding=1, gnt and rvalid in the same cycle -> outstanding_o stays 1; FIFO head advances.
  - Protocol: rvalid=1 with outstanding=0 -> protocol_err_o=1 that cycle; outstanding_o stays 0.
  - Parity: gntpar_i=gnt_i=1 on the second grant -> integrity_err_o=1 at once; resp_integrity_err_o=1 only on the second response.
  - Reset: rst_n=0 while in REGISTERED with 2 outstanding -> next cycle state TRANSPARENT, outstanding_o=0, obi_req_o follows trans_valid_i.
